// File: rtl/pipe_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_scoreboard_if
// Description : Issue-side bundle between the ID stage and the register
//               scoreboard. The master (ID/control) presents the instruction
//               in ID. The slave (scoreboard) answers with issue/stall
//               decisions, register pending state and a stall counter.
// Ports       : none (signals only)
//               master: drives issue_* and flush_i;
//                       receives issue_ok_o, stall_o, busy_o, pending_o,
//                       lat_err_o and stall_cnt_o
//               slave : mirror of master
// Revision    : 1.0  initial release
// ============================================================================
interface pipe_scoreboard_if #(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int LW   = 3,
    parameter int SCW  = 16
);
    logic            issue_valid_i;
    logic [AW-1:0]   issue_rs_i;
    logic [AW-1:0]   issue_rt_i;
    logic            issue_rs_use_i;
    logic            issue_rt_use_i;
    logic            issue_wr_i;
    logic [AW-1:0]   issue_rd_i;
    logic [LW-1:0]   issue_lat_i;
    logic            flush_i;
    logic            issue_ok_o;
    logic            stall_o;
    logic            busy_o;
    logic [NREG-1:0] pending_o;
    logic            lat_err_o;
    logic [SCW-1:0]  stall_cnt_o;

    modport master (
        output issue_valid_i, issue_rs_i, issue_rt_i, issue_rs_use_i,
               issue_rt_use_i, issue_wr_i, issue_rd_i, issue_lat_i, flush_i,
        input  issue_ok_o, stall_o, busy_o, pending_o, lat_err_o, stall_cnt_o
    );

    modport slave (
        input  issue_valid_i, issue_rs_i, issue_rt_i, issue_rs_use_i,
               issue_rt_use_i, issue_wr_i, issue_rd_i, issue_lat_i, flush_i,
        output issue_ok_o, stall_o, busy_o, pending_o, lat_err_o, stall_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/pipe_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : pipe_scoreboard
// Description : Register scoreboard for the ID stage. It keeps a countdown
//               per architectural register for variable-latency producers,
//               and a write-back slot occupancy vector. Each cycle it decides
//               whether the instruction in ID issues or stalls (RAW, WAW or
//               write-port conflict). It also counts stall cycles, saturating.
// Ports       : clk_i  - clock, rising edge
//               rst_i  - asynchronous reset, active low
//               sb     - pipe_scoreboard_if.slave (issue request in,
//                        issue_ok/stall/busy/pending/lat_err/stall_cnt out)
// Revision    : 1.0  initial release
// ============================================================================
module pipe_scoreboard #(
    parameter int NREG    = 32,
    parameter int AW      = 5,
    parameter int MAX_LAT = 7,
    parameter int LW      = 3,
    parameter int SCW     = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    pipe_scoreboard_if.slave sb
);
    localparam int c_slots = MAX_LAT + 1;

    // cnt[r] is the number of cycles, counted from the current cycle, before
    // register r is bypassable. A producer issued with latency L is therefore
    // loaded with L-1, so a consumer issued exactly L cycles later finds 0.
    logic [LW-1:0]      r_cnt [NREG];
    logic [c_slots-1:0] r_slot;
    logic [SCW-1:0]     r_stall_cnt;

    logic [LW-1:0]      w_lat;
    logic               w_lat_bad;
    logic               w_rd_nz;
    logic               w_raw;
    logic               w_waw;
    logic               w_port;
    logic               w_active;
    logic               w_stall;
    logic               w_ok;
    logic               w_track;
    logic [c_slots-1:0] w_slot_nxt;
    logic [NREG-1:0]    w_pending;

    // The range check is done one bit wider so that it remains a real
    // comparison when MAX_LAT fills the whole latency field.
    always_comb begin
        w_lat_bad = (sb.issue_lat_i == '0) ||
                    ({1'b0, sb.issue_lat_i} > (LW+1)'(MAX_LAT));
        if (sb.issue_lat_i == '0) begin
            w_lat = LW'(1);
        end else if ({1'b0, sb.issue_lat_i} > (LW+1)'(MAX_LAT)) begin
            w_lat = LW'(MAX_LAT);
        end else begin
            w_lat = sb.issue_lat_i;
        end
    end

    assign w_rd_nz = (sb.issue_rd_i != '0);

    assign w_raw = (sb.issue_rs_use_i && (sb.issue_rs_i != '0) && (r_cnt[sb.issue_rs_i] != '0)) ||
                   (sb.issue_rt_use_i && (sb.issue_rt_i != '0) && (r_cnt[sb.issue_rt_i] != '0));

    // An older write to the same register that completes after this one.
    assign w_waw  = sb.issue_wr_i && w_rd_nz && (r_cnt[sb.issue_rd_i] > w_lat);

    // Another write already owns the write-back port in the cycle this one would use.
    assign w_port = sb.issue_wr_i && w_rd_nz && r_slot[w_lat];

    // Gating with rst_i forces the combinational outputs low during reset;
    // flush_i masks both the stall and the issue of the squashed instruction.
    assign w_active = rst_i && sb.issue_valid_i && !sb.flush_i;
    assign w_stall  = w_active && (w_raw || w_waw || w_port);
    assign w_ok     = w_active && !w_stall;
    assign w_track  = w_ok && sb.issue_wr_i && w_rd_nz;

    always_comb begin
        w_slot_nxt = r_slot >> 1;
        if (w_track) begin
            w_slot_nxt[w_lat - LW'(1)] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int r = 0; r < NREG; r++) begin
                r_cnt[r] <= '0;
            end
            r_slot      <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_cnt[0] <= '0;
            for (int r = 1; r < NREG; r++) begin
                if (w_track && (sb.issue_rd_i == AW'(r))) begin
                    r_cnt[r] <= w_lat - LW'(1);
                end else if (r_cnt[r] != '0) begin
                    r_cnt[r] <= r_cnt[r] - LW'(1);
                end
            end
            r_slot <= w_slot_nxt;
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + SCW'(1);
            end
        end
    end

    for (genvar r = 0; r < NREG; r++) begin : g_pend
        assign w_pending[r] = (r_cnt[r] != '0);
    end

    assign sb.issue_ok_o  = w_ok;
    assign sb.stall_o     = w_stall;
    assign sb.pending_o   = w_pending;
    assign sb.busy_o      = |w_pending;
    assign sb.lat_err_o   = w_ok && sb.issue_wr_i && w_lat_bad;
    assign sb.stall_cnt_o = r_stall_cnt;
endmodule
`default_nettype wire

// File: tb/tb_pipe_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_scoreboard
// Description : Directed testbench for pipe_scoreboard. One task per
//               scenario; each drives stimulus and checks its own results
//               against hand-computed values.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_scoreboard;
    localparam int NREG    = 32;
    localparam int AW      = 5;
    localparam int MAX_LAT = 7;
    localparam int LW      = 3;
    localparam int SCW     = 16;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    pipe_scoreboard_if #(.NREG(NREG), .AW(AW), .LW(LW), .SCW(SCW)) sb_if ();

    pipe_scoreboard #(
        .NREG(NREG), .AW(AW), .MAX_LAT(MAX_LAT), .LW(LW), .SCW(SCW)
    ) u_dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .sb    (sb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [AW-1:0] rs, input logic rsu,
                         input logic [AW-1:0] rt, input logic rtu, input logic wr,
                         input logic [AW-1:0] rd, input logic [LW-1:0] lat, input logic fl);
        sb_if.issue_valid_i  = v;
        sb_if.issue_rs_i     = rs;
        sb_if.issue_rs_use_i = rsu;
        sb_if.issue_rt_i     = rt;
        sb_if.issue_rt_use_i = rtu;
        sb_if.issue_wr_i     = wr;
        sb_if.issue_rd_i     = rd;
        sb_if.issue_lat_i    = lat;
        sb_if.flush_i        = fl;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        idle();
        repeat (8) step();
    endtask

    task automatic test_reset();
        // reset asserted from time zero with an otherwise issuable write
        drive(1'b1, '0, 1'b0, '0, 1'b0, 1'b1, 5'd7, 3'd0, 1'b0);
        #2;
        checks++; if (sb_if.issue_ok_o !== 1'b0) begin failures++; $display("FAIL rst_issue_ok got=%0b exp=0", sb_if.issue_ok_o); end
        checks++; if (sb_if.lat_err_o !== 1'b0) begin failures++; $display("FAIL rst_lat_err got=%0b exp=0", sb_if.lat_err_o); end
        checks++; if (sb_if.pending_o !== 32'h0) begin failures++; $display("FAIL rst_pending got=%0h exp=0", sb_if.pending_o); end
        checks++; if (sb_if.stall_cnt_o !== 16'h0) begin failures++; $display("FAIL rst_stall_cnt got=%0h exp=0", sb_if.stall_cnt_o); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle();
        step();
        // producer r5 lat 4 leaves cnt[5] = 3
        drive(1'b1, '0, 1'b0, '0, 1'b0, 1'b1, 5'd5, 3'd4, 1'b0);
        checks++; if (sb_if.issue_ok_o !== 1'b1) begin failures++; $display("FAIL mid_issue_ok got=%0b exp=1", sb_if.issue_ok_o); end
        step();
        checks++; if (sb_if.pending_o !== 32'h0000_0020) begin failures++; $display("FAIL mid_pending got=%0h exp=20", sb_if.pending_o); end
        // async reset with a RAW-blocked consumer in ID
        rst_n = 1'b0;
        drive(1'b1, 5'd5, 1'b1, '0, 1'b0, 1'b0, '0, 3'd1, 1'b0);
        checks++; if (sb_if.stall_o !== 1'b0) begin failures++; $display("FAIL arst_stall got=%0b exp=0", sb_if.stall_o); end
        checks++; if (sb_if.issue_ok_o !== 1'b0) begin failures++; $display("FAIL arst_issue_ok got=%0b exp=0", sb_if.issue_ok_o); end
        checks++; if (sb_if.pending_o !== 32'h0) begin failures++; $display("FAIL arst_pending got=%0h exp=0", sb_if.pending_o); end
        checks++; if (sb_if.busy_o !== 1'b0) begin failures++; $display("FAIL arst_busy got=%0b exp=0", sb_if.busy_o); end
        step();
        rst_n = 1'b1;
        idle();
        checks++; if (sb_if.pending_o !== 32'h0) begin failures++; $display("FAIL post_rst_pending got=%0h exp=0", sb_if.pending_o); end
        step();
    endtask

    task automatic test_load_use();
        drive(1'b1, '0, 1'b0, '0, 1'b0, 1'b1, 5'd8, 3'd2, 1'b0);
        checks++; if (sb_if.issue_ok_o !== 1'b1) begin failures++; $display("FAIL lu_prod_ok got=%0b exp=1", sb_if.issue_ok_o); end
        step();
        drive(1'b1, 5'd8, 1'b1, '0, 1'b0, 1'b0, '0, 3'd1, 1'b0);
        checks++; if (sb_if.stall_o !== 1'b1) begin failures++; $display("FAIL lu_stall got=%0b exp=1", sb_if.stall_o); end
        checks++; if (sb_if.pending_o[8] !== 1'b1) begin failures++; $display("FAIL lu_pending got=%0b exp=1", sb_if.pending_o[8]); end
        step();
        checks++; if (sb_if.issue_ok_o !== 1'b1) begin failures++; $display("FAIL lu_cons_ok got=%0b exp=1", sb_if.issue_ok_o); end
        checks++; if (sb_if.stall_cnt_o !== 16'd1) begin failures++; $display("FAIL lu_stall_cnt got=%0d exp=1", sb_if.stall_cnt_o); end
        step();
        idle();
    endtask

    task automatic test_back_to_back();
        drive(1'b1, '0, 1'b0, '0, 1'b0, 1'b1, 5'd9, 3'd1, 1'b0);
        step();
        checks++; if (sb_if.pending_o[9] !== 1'b0) begin failures++; $display("FAIL b2b_pending got=%0b exp=0", sb_if.pending_o[9]); end
        drive(1'b1, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0, '0, 3'd1, 1'b0);
        checks++; if (sb_if.issue_ok_o !== 1'b1) begin failures++; $display("FAIL b2b_ok got=%0b exp=1", sb_if.issue_ok_o); end
        checks++; if (sb_if.stall_o !== 1'b0) begin failures++; $display("FAIL b2b_stall got=%0b exp=0", sb_if.stall_o); end
        step();
        // RAW through rt only: lat 3 -> two stall cycles
        drive(1'b1, '0, 1'b0, '0, 1'b0, 1'b1, 5'd10, 3'd3, 1'b0);
        step();
        drive(1'b1, 5'd10, 1'b0, 5'd10, 1'b1, 1'b0, '0, 3'd1, 1'b0);
        checks++; if (sb_if.stall_o !== 1'b1) begin failures++; $display("FAIL rt_stall0 got=%0b exp=1", sb_if.stall_o); end
        step();
        checks++; if (sb_if.stall_o !== 1'b1) begin failures++; $display("FAIL rt_stall1 got=%0b exp=1", sb_if.stall_o); end
        step();
        checks++; if (sb_if.issue_ok_o !== 1'b1) begin failures++; $display("FAIL rt_ok got=%0b exp=1", sb_if.issue_ok_o); end
        checks++; if (sb_if.stall_cnt_o !== 16'd3) begin failures++; $display("FAIL rt_stall_cnt got=%0d exp=3", sb_if.stall_cnt_o); end
        step();
        idle();
    endtask

    task automatic test_waw();
        drive(1'b1, '0, 1'b0, '0, 1'b0, 1'b1, 5'd3, 3'd6, 1'b0);
        checks++; if (sb_if.issue_ok_o !== 1'b1) begin failures++; $display("FAIL waw_prod_ok got=%0b exp=1", sb_if.issue_ok_o); end
        step();
        drive(1'b1, '0, 1'b0, '0, 1'b0, 1'b1, 5'd3, 3'd1, 1'b0);
        // WAW while cnt[3] = 5..2, then a port clash while it completes in 1
        for (int i = 0; i < 5; i++) begin
            checks++; if (sb_if.stall_o !== 1'b1) begin failures++; $display("FAIL waw_stall%0d got=%0b exp=1", i, sb_if.stall_o); end
            step();
        end
        checks++; if (sb_if.issue_ok_o !== 1'b1) begin failures++; $display("FAIL waw_ok got=%0b exp=1", sb_if.issue_ok_o); end
        step();
        idle();
        checks++; if (sb_if.stall_cnt_o !== 16'd8) begin failures++; $display("FAIL waw_stall_cnt got=%0d exp=8", sb_if.stall_cnt_o); end
        drain();
    endtask

    task automatic test_port();
        drive(1'b1, '0, 1'b0, '0, 1'b0, 1'b1, 5'd20, 3'd6, 1'b0);
        step();
        drive(1'b1, '0, 1'b0, '0, 1'b0, 1'b1, 5'd4, 3'd5, 1'b0);
        checks++; if (sb_if.stall_o !== 1'b1) begin failures++; $display("FAIL port_stall got=%0b exp=1", sb_if.stall_o); end
        step();
        checks++; if (sb_if.issue_ok_o !== 1'b1) begin failures++; $display("FAIL port_ok got=%0b exp=1", sb_if.issue_ok_o); end
        step();
        idle();
        checks++; if (sb_if.stall_cnt_o !== 16'd9) begin failures++; $display("FAIL port_stall_cnt got=%0d exp=9", sb_if.stall_cnt_o); end
        drain();
    endtask

    task automatic test_flush();
        drive(1'b1, '0, 1'b0, '0, 1'b0, 1'b1, 5'd12, 3'd4, 1'b0);
        step();
        drive(1'b1, 5'd12, 1'b1, '0, 1'b0, 1'b1, 5'd13, 3'd3, 1'b1);
        checks++; if (sb_if.stall_o !== 1'b0) begin failures++; $display("FAIL fl_stall got=%0b exp=0", sb_if.stall_o); end
        checks++; if (sb_if.issue_ok_o !== 1'b0) begin failures++; $display("FAIL fl_ok got=%0b exp=0", sb_if.issue_ok_o); end
        step();
        checks++; if (sb_if.pending_o[13] !== 1'b0) begin failures++; $display("FAIL fl_no_track got=%0b exp=0", sb_if.pending_o[13]); end
        checks++; if (sb_if.pending_o[12] !== 1'b1) begin failures++; $display("FAIL fl_cnt_kept got=%0b exp=1", sb_if.pending_o[12]); end
        drive(1'b1, 5'd12, 1'b1, '0, 1'b0, 1'b1, 5'd13, 3'd3, 1'b0);
        checks++; if (sb_if.stall_o !== 1'b1) begin failures++; $display("FAIL fl_after_stall got=%0b exp=1", sb_if.stall_o); end
        step();
        idle();
        checks++; if (sb_if.stall_cnt_o !== 16'd10) begin failures++; $display("FAIL fl_stall_cnt got=%0d exp=10", sb_if.stall_cnt_o); end
        drain();
    endtask

    task automatic test_edge();
        drive(1'b1, '0, 1'b0, '0, 1'b0, 1'b1, 5'd0, 3'd7, 1'b0);
        checks++; if (sb_if.issue_ok_o !== 1'b1) begin failures++; $display("FAIL r0_ok got=%0b exp=1", sb_if.issue_ok_o); end
        checks++; if (sb_if.lat_err_o !== 1'b0) begin failures++; $display("FAIL r0_lat_err got=%0b exp=0", sb_if.lat_err_o); end
        step();
        checks++; if (sb_if.busy_o !== 1'b0) begin failures++; $display("FAIL r0_busy got=%0b exp=0", sb_if.busy_o); end
        // a write to r0 must not have claimed the slot this one needs
        drive(1'b1, '0, 1'b0, '0, 1'b0, 1'b1, 5'd5, 3'd6, 1'b0);
        checks++; if (sb_if.issue_ok_o !== 1'b1) begin failures++; $display("FAIL r0_noslot_ok got=%0b exp=1", sb_if.issue_ok_o); end
        step();
        drive(1'b1, '0, 1'b0, '0, 1'b0, 1'b1, 5'd6, 3'd0, 1'b0);
        checks++; if (sb_if.lat_err_o !== 1'b1) begin failures++; $display("FAIL lat0_err got=%0b exp=1", sb_if.lat_err_o); end
        checks++; if (sb_if.issue_ok_o !== 1'b1) begin failures++; $display("FAIL lat0_ok got=%0b exp=1", sb_if.issue_ok_o); end
        step();
        checks++; if (sb_if.pending_o[6] !== 1'b0) begin failures++; $display("FAIL lat0_pending got=%0b exp=0", sb_if.pending_o[6]); end
        drive(1'b1, '0, 1'b0, '0, 1'b0, 1'b0, 5'd7, 3'd0, 1'b0);
        checks++; if (sb_if.lat_err_o !== 1'b0) begin failures++; $display("FAIL lat0_nowr_err got=%0b exp=0", sb_if.lat_err_o); end
        step();
        drain();
    endtask

    task automatic test_saturation();
        // self-sustaining pattern: one issue (r1, lat 7) then six RAW stalls,
        // for 76500 cycles -> 65571 more stalls, past the 16-bit limit
        drive(1'b1, 5'd1, 1'b1, '0, 1'b0, 1'b1, 5'd1, 3'd7, 1'b0);
        repeat (76500) @(posedge clk);
        #1;
        checks++; if (sb_if.stall_cnt_o !== 16'hFFFF) begin failures++; $display("FAIL sat_stall_cnt got=%0h exp=ffff", sb_if.stall_cnt_o); end
        idle();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        test_reset();
        test_load_use();
        test_back_to_back();
        test_waw();
        test_port();
        test_flush();
        test_edge();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
